keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: walks one active-low column per tick, debounces press/release, reports one code per press.
// Latency: 2-cycle row synchronizer plus DEBOUNCE_TICKS ticks from a stable press to key_valid.
// Backpressure: key_valid/key_code hold in REPORT until key_ready; scanning is suspended meanwhile.
module keypad_scan_ctrl #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       busy
);

    localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        REPORT   = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] col_idx, col_nxt;
    logic [1:0] cap_row, cap_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] cnt_inc;
    logic [3:0] rs_meta, rs;

    // Lowest-numbered active row wins when several rows are low together.
    function automatic logic [1:0] low_zero(input logic [3:0] v);
        if (!v[0])      return 2'd0;
        else if (!v[1]) return 2'd1;
        else if (!v[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_meta <= 4'hF;
            rs      <= 4'hF;
        end else begin
            rs_meta <= row_n;
            rs      <= rs_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            cap_row <= 2'd0;
            cnt     <= 4'd0;
        end else begin
            state   <= state_nxt;
            col_idx <= col_nxt;
            cap_row <= cap_nxt;
            cnt     <= cnt_nxt;
        end
    end

    assign cnt_inc = cnt + 4'd1;

    always_comb begin
        state_nxt = state;
        col_nxt   = col_idx;
        cap_nxt   = cap_row;
        cnt_nxt   = cnt;
        case (state)
            SCAN: begin
                if (tick) begin
                    if (rs == 4'hF) begin
                        col_nxt = col_idx + 2'd1;
                    end else begin
                        cap_nxt   = low_zero(rs);
                        cnt_nxt   = 4'd1;
                        state_nxt = (DT == 4'd1) ? REPORT : DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (!rs[cap_row]) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc >= DT) state_nxt = REPORT;
                    end else begin
                        state_nxt = SCAN;
                        cnt_nxt   = 4'd0;
                        col_nxt   = col_idx + 2'd1;
                    end
                end
            end
            REPORT: begin
                if (key_ready) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = 4'd0;
                end
            end
            RELEASE: begin
                // Any low sample restarts the release count so a bouncy release cannot re-trigger.
                if (tick) begin
                    if (rs[cap_row]) begin
                        if (cnt_inc >= DT) begin
                            state_nxt = SCAN;
                            cnt_nxt   = 4'd0;
                            col_nxt   = col_idx + 2'd1;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt = 4'd0;
                    end
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_comb begin
        col_n     = ~(4'b0001 << col_idx);
        key_code  = {cap_row, col_idx};
        key_valid = (state == REPORT);
        busy      = (state != SCAN);
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model drives rows from the driven column and a pressed-key mask.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       busy;

    logic [15:0] pressed;
    logic [3:0]  sb[$];
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    int          valid_cycles = 0;
    int          pushes = 0;

    typedef struct packed {
        logic [15:0] mask;
        logic [3:0]  code;
    } vec_t;
    vec_t vecs[5];

    keypad_scan_ctrl #(.DEBOUNCE_TICKS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Closed switch at (r,c) pulls row r low only while column c is driven.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
        end
    end

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) valid_cycles++;
            if (key_valid && key_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_report got code %0d expected none", key_code);
                end else begin
                    check("report_code", int'(key_code), int'(sb.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic settle();
        repeat (3) step();
    endtask

    task automatic expect_key(input logic [3:0] code);
        sb.push_back(code);
        pushes++;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 400 && !key_valid; i++) begin
            tick = (i % 4 == 3);
            step();
            tick = 1'b0;
        end
        check("valid_timeout", int'(key_valid), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy; i++) begin
            tick = (i % 4 == 3);
            step();
            tick = 1'b0;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, h0, bad;
        logic [3:0] e;

        vecs[0] = '{mask: 16'h8080, code: 4'd7};
        vecs[1] = '{mask: 16'h0001, code: 4'd0};
        vecs[2] = '{mask: 16'h0040, code: 4'd6};
        vecs[3] = '{mask: 16'h2000, code: 4'd13};
        vecs[4] = '{mask: 16'h0808, code: 4'd3};

        rst = 1'b1; tick = 1'b0; key_ready = 1'b0; pressed = 16'h0;
        step(); step();
        check("rst_col_n", int'(col_n), 14);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_key_code", int'(key_code), 0);
        rst = 1'b0;
        step();

        // Idle scan: column walks 0..3 and wraps.
        for (int k = 1; k <= 8; k++) begin
            pulse_tick();
            step(); step(); step();
            e = 4'b0001 << (k % 4);
            e = ~e;
            check("idle_col_n", int'(col_n), int'(e));
            check("idle_busy", int'(busy), 0);
            check("idle_valid", int'(key_valid), 0);
        end

        // Clean press of row 2 / column 1.
        key_ready = 1'b1;
        expect_key(4'd9);
        pressed = 16'h0200;
        v0 = valid_cycles;
        wait_valid();
        check("clean_code", int'(key_code), 9);
        step();
        check("clean_valid_width", valid_cycles - v0, 1);
        check("clean_valid_low", int'(key_valid), 0);
        h0 = hs_cnt;
        for (int k = 0; k < 10; k++) begin
            pulse_tick();
            settle();
        end
        check("held_no_repeat", hs_cnt - h0, 0);
        check("held_busy", int'(busy), 1);
        check("held_col_n", int'(col_n), 13);
        pressed = 16'h0;
        settle(); pulse_tick();
        check("release_t1_busy", int'(busy), 1);
        settle(); pulse_tick();
        check("release_t2_busy", int'(busy), 1);
        settle(); pulse_tick();
        check("release_t3_busy", int'(busy), 0);
        check("release_col_n", int'(col_n), 11);
        check("release_no_repeat", hs_cnt - h0, 0);

        // Bounce on column 2: low for two ticks, high on the third.
        v0 = valid_cycles;
        pressed = 16'h0004;
        settle(); pulse_tick();
        check("bounce_t1_busy", int'(busy), 1);
        check("bounce_t1_col_n", int'(col_n), 11);
        settle(); pulse_tick();
        check("bounce_t2_busy", int'(busy), 1);
        pressed = 16'h0;
        settle(); pulse_tick();
        check("bounce_busy", int'(busy), 0);
        check("bounce_col_n", int'(col_n), 7);
        check("bounce_no_valid", valid_cycles - v0, 0);

        for (int i = 0; i < 5; i++) begin
            expect_key(vecs[i].code);
            pressed = vecs[i].mask;
            wait_valid();
            check("vec_code", int'(key_code), int'(vecs[i].code));
            step();
            check("vec_valid_low", int'(key_valid), 0);
            pressed = 16'h0;
            wait_idle();
        end

        // Backpressure: hold for 20 cycles, ticks ignored in REPORT.
        key_ready = 1'b0;
        expect_key(4'd4);
        pressed = 16'h0010;
        wait_valid();
        h0 = hs_cnt;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick = (c % 3 == 0);
            step();
            tick = 1'b0;
            if (!(key_valid === 1'b1 && key_code === 4'd4)) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_no_hs", hs_cnt - h0, 0);
        key_ready = 1'b1;
        step();
        check("bp_hs_once", hs_cnt - h0, 1);
        check("bp_valid_low", int'(key_valid), 0);
        pressed = 16'h0;
        wait_idle();

        // Reset while a key is pending in REPORT.
        key_ready = 1'b0;
        pressed = 16'h0020;
        wait_valid();
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", int'(key_valid), 0);
        check("arst_col_n", int'(col_n), 14);
        check("arst_busy", int'(busy), 0);
        check("arst_key_code", int'(key_code), 0);
        pressed = 16'h0;
        key_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        step();

        // First tick after reset is evaluated on column 0.
        pressed = 16'h0001;
        settle(); pulse_tick();
        check("post_rst_busy", int'(busy), 1);
        check("post_rst_col_n", int'(col_n), 14);
        expect_key(4'd0);
        wait_valid();
        step();
        pressed = 16'h0;
        wait_idle();

        // Tick held high: every cycle advances the column.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        tick = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            e = 4'b0001 << (k % 4);
            e = ~e;
            check("cont_tick_col_n", int'(col_n), int'(e));
        end
        tick = 1'b0;
        step();

        check("sb_empty", sb.size(), 0);
        check("report_count", hs_cnt, pushes);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
